// File: rtl/aether_cmd_decoder_if.sv
// aether_cmd_decoder_if: 24-bit host command bus plus the 16-bit read-back path.
// Bus protocol: there is no ready and no backpressure. The responder samples
// instruction/param_1/param_2 on every rising clk edge. Each non-NOP opcode
// present at an edge counts as one command, so holding an opcode repeats it.
// data is a registered response, valid from the cycle after the command.
interface aether_cmd_decoder_if;
   logic [3:0]  instruction;
   logic [3:0]  param_1;
   logic [15:0] param_2;
   logic [15:0] data;

   modport master (output instruction, output param_1, output param_2, input data);
   modport slave  (input instruction, input param_1, input param_2, output data);
endinterface

// File: rtl/aether_cmd_decoder.sv
// aether_cmd_decoder: engine-side responder for the host command bus.
// Owns the register file, the sticky status and interrupt flags, the
// IDLE/CONV/LOADW/RESET sequencer, and the strobes to the engine datapaths.
// Optional feature macro: AETHER_CMD_COUNT_EN. When it is defined, register 15
// (REG_CMDCT) counts accepted commands. When it is undefined, register 15 reads 0.
module aether_cmd_decoder #(
   parameter int RegCount  = 16,
   parameter int RstCycles = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   aether_cmd_decoder_if.slave    bus,
   output logic                   interrupt_o,
   output logic [RegCount*16-1:0] regs_o,
   output logic                   soft_rst_o,
   output logic                   conv_start_o,
   input  logic                   conv_done_i,
   output logic                   ldw_start_o,
   input  logic                   ldw_done_i,
   output logic                   lip_valid_o,
   output logic                   lip_first_o,
   output logic [15:0]            lip_data_o,
   output logic                   rop_req_o,
   output logic                   rop_first_o,
   input  logic                   rop_valid_i,
   input  logic [15:0]            rop_data_i,
   output logic [1:0]             dbg_state_o
);

   // Sequencer states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CONV  = 2'd1;
   localparam logic [1:0] S_LOADW = 2'd2;
   localparam logic [1:0] S_RESET = 2'd3;

   // Opcodes
   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_RST = 4'd1;
   localparam logic [3:0] OP_RDR = 4'd2;
   localparam logic [3:0] OP_WRR = 4'd3;
   localparam logic [3:0] OP_LDW = 4'd4;
   localparam logic [3:0] OP_LIP = 4'd5;
   localparam logic [3:0] OP_CNV = 4'd6;
   localparam logic [3:0] OP_ROP = 4'd7;

   // Sub-ops
   localparam logic [3:0] RST_FULL = 4'd0;
   localparam logic [3:0] LIP_STRT = 4'd0;
   localparam logic [3:0] LIP_CONT = 4'd1;
   localparam logic [3:0] ROP_STRT = 4'd0;

   // Special register indices
   localparam int IDX_STATS = 0;
   localparam int IDX_CMDCT = 15;

   localparam int CW = (RstCycles > 1) ? $clog2(RstCycles) : 1;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] rst_cnt_q, rst_cnt_d;
   logic          soft_rst_q, soft_rst_d;
   logic          conv_done_q, conv_done_d;
   logic          ldw_done_q, ldw_done_d;
   logic          illegal_q, illegal_d;
   logic          interrupt_q, interrupt_d;
   logic          conv_start_q, conv_start_d;
   logic          ldw_start_q, ldw_start_d;
   logic          lip_valid_q, lip_valid_d;
   logic          lip_first_q, lip_first_d;
   logic [15:0]   lip_data_q, lip_data_d;
   logic          rop_req_q, rop_req_d;
   logic          rop_first_q, rop_first_d;
   logic [15:0]   data_q, data_d;

   logic [3:0]    op;
   logic [3:0]    p1;
   logic [15:0]   p2;
   logic          live;
   logic          illegal_cmd;
   logic          accept;
   logic          rst_full;
   logic          wr_en;
   logic          rd_stats;
   logic [15:0]   rd_val;
   logic [15:0]   stats;
   logic [15:0]   cmdct_val;

   assign op = bus.instruction;
   assign p1 = bus.param_1;
   assign p2 = bus.param_2;

   // Status word: sticky done/illegal flags plus live busy bits
   assign stats = {11'd0, illegal_q, (state_q == S_LOADW), (state_q == S_CONV),
                   ldw_done_q, conv_done_q};

   // Classify the command on the bus: accepted, illegal, or dropped during RESET
   always_comb begin
      live        = (state_q != S_RESET);
      illegal_cmd = 1'b0;
      if (live) begin
         case (op)
            OP_NOP, OP_RDR, OP_ROP: illegal_cmd = 1'b0;
            OP_RST: illegal_cmd = (p1 != RST_FULL);
            OP_WRR: illegal_cmd = (int'(p1) == IDX_STATS) || (int'(p1) == IDX_CMDCT) ||
                                  (int'(p1) >= RegCount);
            OP_LDW, OP_CNV: illegal_cmd = (state_q != S_IDLE);
            OP_LIP: illegal_cmd = (p1 > LIP_CONT);
            default: illegal_cmd = 1'b1;
         endcase
      end
      accept   = live && (op != OP_NOP) && !illegal_cmd;
      rst_full = accept && (op == OP_RST);
      wr_en    = accept && (op == OP_WRR);
      rd_stats = accept && (op == OP_RDR) && (int'(p1) == IDX_STATS);
   end

   // Read mux over the visible register file, including status and command count
   always_comb begin
      rd_val = '0;
      if (int'(p1) < RegCount) rd_val = regs_o[16*p1 +: 16];
   end

   // Next-state logic for the sequencer, flags, strobes and read-back data
   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      soft_rst_d   = soft_rst_q;
      conv_done_d  = conv_done_q;
      ldw_done_d   = ldw_done_q;
      illegal_d    = illegal_q;
      interrupt_d  = conv_done_q | ldw_done_q;
      conv_start_d = 1'b0;
      ldw_start_d  = 1'b0;
      lip_valid_d  = 1'b0;
      lip_first_d  = 1'b0;
      lip_data_d   = lip_data_q;
      rop_req_d    = 1'b0;
      rop_first_d  = 1'b0;
      data_d       = data_q;

      // A result word lands on data unless a register read claims it below
      if (rop_valid_i) data_d = rop_data_i;

      // Read-to-clear comes first so a done pulse in the same cycle survives
      if (rd_stats) begin
         conv_done_d = 1'b0;
         ldw_done_d  = 1'b0;
         illegal_d   = 1'b0;
      end
      if (illegal_cmd) illegal_d = 1'b1;

      if ((state_q == S_CONV) && conv_done_i) begin
         conv_done_d = 1'b1;
         state_d     = S_IDLE;
      end
      if ((state_q == S_LOADW) && ldw_done_i) begin
         ldw_done_d = 1'b1;
         state_d    = S_IDLE;
      end

      if (accept) begin
         case (op)
            OP_RDR: data_d = rd_val;
            OP_CNV: begin
               state_d      = S_CONV;
               conv_start_d = 1'b1;
            end
            OP_LDW: begin
               state_d     = S_LOADW;
               ldw_start_d = 1'b1;
            end
            OP_LIP: begin
               lip_valid_d = 1'b1;
               lip_first_d = (p1 == LIP_STRT);
               lip_data_d  = p2;
            end
            OP_ROP: begin
               rop_req_d   = 1'b1;
               rop_first_d = (p1 == ROP_STRT);
            end
            OP_RST: begin
               state_d     = S_RESET;
               soft_rst_d  = 1'b1;
               rst_cnt_d   = CW'(RstCycles - 1);
               conv_done_d = 1'b0;
               ldw_done_d  = 1'b0;
               illegal_d   = 1'b0;
            end
            default: data_d = data_d;
         endcase
      end

      // Hold soft reset for RstCycles cycles, then return to IDLE
      if (state_q == S_RESET) begin
         if (rst_cnt_q == '0) begin
            state_d    = S_IDLE;
            soft_rst_d = 1'b0;
         end else begin
            rst_cnt_d = rst_cnt_q - 1'b1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         rst_cnt_q    <= '0;
         soft_rst_q   <= 1'b0;
         conv_done_q  <= 1'b0;
         ldw_done_q   <= 1'b0;
         illegal_q    <= 1'b0;
         interrupt_q  <= 1'b0;
         conv_start_q <= 1'b0;
         ldw_start_q  <= 1'b0;
         lip_valid_q  <= 1'b0;
         lip_first_q  <= 1'b0;
         lip_data_q   <= '0;
         rop_req_q    <= 1'b0;
         rop_first_q  <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         soft_rst_q   <= soft_rst_d;
         conv_done_q  <= conv_done_d;
         ldw_done_q   <= ldw_done_d;
         illegal_q    <= illegal_d;
         interrupt_q  <= interrupt_d;
         conv_start_q <= conv_start_d;
         ldw_start_q  <= ldw_start_d;
         lip_valid_q  <= lip_valid_d;
         lip_first_q  <= lip_first_d;
         lip_data_q   <= lip_data_d;
         rop_req_q    <= rop_req_d;
         rop_first_q  <= rop_first_d;
         data_q       <= data_d;
      end
   end

`ifdef AETHER_CMD_COUNT_EN
   logic [15:0] cmdct_q;

   // Count accepted commands; a full soft reset restarts the count at zero
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         cmdct_q <= '0;
      else if (rst_full) cmdct_q <= '0;
      else if (accept)   cmdct_q <= cmdct_q + 16'd1;
   end

   assign cmdct_val = cmdct_q;
`else
   assign cmdct_val = '0;
`endif

   // Register file: slot 0 is the status word, slot 15 the command count
   for (genvar n = 0; n < RegCount; n++) begin : g_reg
      if (n == IDX_STATS) begin : g_stats
         assign regs_o[16*n +: 16] = stats;
      end else if (n == IDX_CMDCT) begin : g_cmdct
         assign regs_o[16*n +: 16] = cmdct_val;
      end else begin : g_rw
         logic [15:0] reg_q;

         // Host write to this index; a full soft reset clears it
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)                          reg_q <= '0;
            else if (rst_full)                  reg_q <= '0;
            else if (wr_en && (int'(p1) == n))  reg_q <= p2;
         end

         assign regs_o[16*n +: 16] = reg_q;
      end
   end

   assign bus.data     = data_q;
   assign interrupt_o  = interrupt_q;
   assign soft_rst_o   = soft_rst_q;
   assign conv_start_o = conv_start_q;
   assign ldw_start_o  = ldw_start_q;
   assign lip_valid_o  = lip_valid_q;
   assign lip_first_o  = lip_first_q;
   assign lip_data_o   = lip_data_q;
   assign rop_req_o    = rop_req_q;
   assign rop_first_o  = rop_first_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_aether_cmd_decoder.sv
// tb_aether_cmd_decoder: directed scenarios for the command decoder, followed
// by a randomized run against a command-level reference model.
module tb_aether_cmd_decoder;

   localparam int RSTC = 4;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic         interrupt_o;
   logic [255:0] regs_o;
   logic         soft_rst_o, conv_start_o, ldw_start_o;
   logic         lip_valid_o, lip_first_o, rop_req_o, rop_first_o;
   logic [15:0]  lip_data_o;
   logic         conv_done_i = 1'b0, ldw_done_i = 1'b0, rop_valid_i = 1'b0;
   logic [15:0]  rop_data_i = '0;
   logic [1:0]   dbg_state_o;

   int tests = 0;
   int fails = 0;

   aether_cmd_decoder_if bus ();

   aether_cmd_decoder #(.RegCount(16), .RstCycles(RSTC)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
      .interrupt_o(interrupt_o), .regs_o(regs_o), .soft_rst_o(soft_rst_o),
      .conv_start_o(conv_start_o), .conv_done_i(conv_done_i),
      .ldw_start_o(ldw_start_o), .ldw_done_i(ldw_done_i),
      .lip_valid_o(lip_valid_o), .lip_first_o(lip_first_o), .lip_data_o(lip_data_o),
      .rop_req_o(rop_req_o), .rop_first_o(rop_first_o),
      .rop_valid_i(rop_valid_i), .rop_data_i(rop_data_i),
      .dbg_state_o(dbg_state_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] p1, input logic [15:0] p2);
      bus.instruction = op;
      bus.param_1     = p1;
      bus.param_2     = p2;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pulses();
      return {soft_rst_o, conv_start_o, ldw_start_o, lip_valid_o,
              lip_first_o, rop_req_o, rop_first_o, interrupt_o};
   endfunction

   // Reference model: command-level view of the block
   int          m_busy;       // 0 nothing running, 1 convolution, 2 weight load
   int          m_rst_left;   // soft-reset cycles still to elapse
   logic        m_cd, m_ld, m_il;
   logic [15:0] m_reg [16];
   logic [15:0] m_cnt;
   logic [15:0] m_data;

   function automatic logic [15:0] m_stats(int busy, logic cd, logic ld, logic il);
      logic [15:0] s;
      s = 16'd0;
      s[0] = cd;
      s[1] = ld;
      s[2] = (busy == 1);
      s[3] = (busy == 2);
      s[4] = il;
      return s;
   endfunction

   function automatic logic [15:0] m_count_view();
`ifdef AETHER_CMD_COUNT_EN
      return m_cnt;
`else
      return 16'd0;
`endif
   endfunction

   function automatic logic [255:0] m_regs_vec();
      logic [255:0] v;
      v = '0;
      for (int i = 1; i < 15; i++) v[16*i +: 16] = m_reg[i];
      v[15:0]    = m_stats(m_busy, m_cd, m_ld, m_il);
      v[255:240] = m_count_view();
      return v;
   endfunction

   initial begin
      logic [3:0]  op, p1;
      logic [15:0] p2, rd, e_data, e_ldat;
      logic        cdi, ldi, rv, live, bad, full;
      logic        e_soft, e_cs, e_ls, e_lv, e_lf, e_rq, e_rf, e_irq;
      logic        n_cd, n_ld, n_il;
      int          n_busy, k, extra;

      // Reset block
      drive(4'd0, 4'd0, 16'd0);
      rst_i = 1'b1;
      tick(); tick();
      chk("reset_data", bus.data, 16'd0);
      chk("reset_regs", regs_o, '0);
      chk("reset_pulses", pulses(), 8'd0);
      chk("reset_lip_data", lip_data_o, 16'd0);
      rst_i = 1'b0;
      tick();

      // 1: register write and read-back
      drive(4'd3, 4'd1, 16'h4002); tick();
      chk("wrr_idx1", regs_o[31:16], 16'h4002);
      drive(4'd3, 4'd4, 16'h0040); tick();
      chk("wrr_idx4", regs_o[79:64], 16'h0040);
      drive(4'd2, 4'd1, 16'h0); tick();
      chk("rdr_idx1", bus.data, 16'h4002);
      drive(4'd0, 4'd0, 16'h0);

      // 2: convolution with done, interrupt and read-to-clear
      drive(4'd6, 4'd0, 16'h0); tick();
      chk("conv_start", conv_start_o, 1'b1);
      drive(4'd0, 4'd0, 16'h0);
      extra = 0;
      for (int i = 0; i < 19; i++) begin
         tick();
         if (conv_start_o) extra++;
      end
      conv_done_i = 1'b1; tick(); conv_done_i = 1'b0;
      tick();
      chk("conv_start_once", extra, 0);
      chk("irq_after_conv", interrupt_o, 1'b1);
      drive(4'd2, 4'd0, 16'h0); tick();
      chk("stats_conv_done", bus.data, 16'h0001);
      drive(4'd0, 4'd0, 16'h0); tick();
      chk("irq_cleared", interrupt_o, 1'b0);

      // 3: LDW while convolving is illegal and ignored
      drive(4'd6, 4'd0, 16'h0); tick();
      drive(4'd4, 4'd0, 16'h0); tick();
      chk("ldw_ignored", ldw_start_o, 1'b0);
      drive(4'd0, 4'd0, 16'h0); tick();
      chk("ldw_ignored_2", ldw_start_o, 1'b0);
      drive(4'd2, 4'd0, 16'h0); tick();
      chk("stats_busy_ill", bus.data, 16'h0014);
      tick();
      chk("stats_busy", bus.data, 16'h0004);
      drive(4'd0, 4'd0, 16'h0);
      conv_done_i = 1'b1; tick(); conv_done_i = 1'b0;
      drive(4'd2, 4'd0, 16'h0); tick();
      chk("stats_conv_done_2", bus.data, 16'h0001);
      drive(4'd0, 4'd0, 16'h0); tick(); tick();

      // 4: done pulse coincides with read-to-clear
      drive(4'd4, 4'd0, 16'h0); tick();
      chk("ldw_start", ldw_start_o, 1'b1);
      drive(4'd0, 4'd0, 16'h0); tick(); tick(); tick();
      drive(4'd2, 4'd0, 16'h0); ldw_done_i = 1'b1; tick(); ldw_done_i = 1'b0;
      chk("stats_ldw_busy", bus.data, 16'h0008);
      drive(4'd0, 4'd0, 16'h0); tick();
      chk("ldw_done_kept", regs_o[15:0], 16'h0002);
      chk("irq_ldw", interrupt_o, 1'b1);
      tick();
      chk("irq_ldw_hold", interrupt_o, 1'b1);
      drive(4'd2, 4'd0, 16'h0); tick();
      chk("stats_ldw_done", bus.data, 16'h0002);
      drive(4'd0, 4'd0, 16'h0); tick(); tick();

      // 5: input strobes and output read
      drive(4'd5, 4'd0, 16'hABCD); tick();
      chk("lip_strt", {lip_valid_o, lip_first_o, lip_data_o}, {2'b11, 16'hABCD});
      drive(4'd5, 4'd1, 16'h1234); tick();
      chk("lip_cont", {lip_valid_o, lip_first_o, lip_data_o}, {2'b10, 16'h1234});
      drive(4'd7, 4'd0, 16'h0); tick();
      chk("rop_strt", {rop_req_o, rop_first_o, lip_valid_o}, 3'b110);
      drive(4'd0, 4'd0, 16'h0); tick();
      rop_valid_i = 1'b1; rop_data_i = 16'h00FF; tick(); rop_valid_i = 1'b0;
      chk("rop_data", bus.data, 16'h00FF);

      // 6: full soft reset during a convolution, with writes dropped
      drive(4'd3, 4'd2, 16'h1111); tick();
      drive(4'd6, 4'd0, 16'h0); tick();
      drive(4'd1, 4'd0, 16'h0); tick();
      extra = soft_rst_o ? 1 : 0;
      drive(4'd3, 4'd3, 16'h5555);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (soft_rst_o) extra++;
      end
      drive(4'd0, 4'd0, 16'h0); tick();
      chk("soft_rst_len", extra, RSTC);
      chk("soft_rst_off", soft_rst_o, 1'b0);
      chk("regs_cleared", regs_o, '0);
      drive(4'd2, 4'd0, 16'h0); tick();
      chk("stats_after_rst", bus.data, 16'h0000);

      // rst_i mid-operation suppresses pending pulses
      drive(4'd5, 4'd0, 16'h7777); tick();
      drive(4'd6, 4'd0, 16'h0);
      #2 rst_i = 1'b1;
      #1 chk("async_rst_pulses", pulses(), 8'd0);
      tick();
      rst_i = 1'b0;
      drive(4'd0, 4'd0, 16'h0); tick();
      chk("async_rst_no_start", {conv_start_o, bus.data}, 17'd0);

      // Randomized run against the reference model
      m_busy = 0; m_rst_left = 0; m_cd = 0; m_ld = 0; m_il = 0;
      m_cnt = '0; m_data = '0; e_ldat = '0;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;

      for (int cyc = 0; cyc < 2000; cyc++) begin
         k = $urandom_range(0, 99);
         if (k < 4)       op = 4'd1;
         else if (k < 10) op = 4'($urandom_range(8, 15));
         else begin
            k = $urandom_range(0, 6);
            op = (k == 0) ? 4'd0 : 4'(k + 1);
         end
         case (op)
            4'd1:       p1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            4'd5, 4'd7: p1 = 4'($urandom_range(0, 2));
            4'd2:       p1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            default:    p1 = 4'($urandom_range(0, 15));
         endcase
         p2  = 16'($urandom);
         cdi = ($urandom_range(0, 7) == 0);
         ldi = ($urandom_range(0, 7) == 0);
         rv  = ($urandom_range(0, 3) == 0);
         rd  = 16'($urandom);

         drive(op, p1, p2);
         conv_done_i = cdi; ldw_done_i = ldi; rop_valid_i = rv; rop_data_i = rd;

         // Expected outputs for this edge, then the model's new state
         e_soft = 0; e_cs = 0; e_ls = 0; e_lv = 0; e_lf = 0; e_rq = 0; e_rf = 0;
         e_irq  = m_cd | m_ld;
         e_data = rv ? rd : m_data;
         n_busy = m_busy; n_cd = m_cd; n_ld = m_ld; n_il = m_il;
         bad = 0; full = 0;
         live = (m_rst_left == 0);
         if (!live) begin
            e_soft = (m_rst_left > 1);
            m_rst_left--;
         end else begin
            case (op)
               4'd0: bad = 0;
               4'd1: if (p1 == 0) full = 1; else bad = 1;
               4'd2: begin
                  if (p1 == 0) begin
                     e_data = m_stats(m_busy, m_cd, m_ld, m_il);
                     n_cd = 0; n_ld = 0; n_il = 0;
                  end else if (p1 == 15) e_data = m_count_view();
                  else e_data = m_reg[p1];
               end
               4'd3: bad = (p1 == 0) || (p1 == 15);
               4'd4: if (m_busy != 0) bad = 1; else begin n_busy = 2; e_ls = 1; end
               4'd5: if (p1 > 1) bad = 1; else begin e_lv = 1; e_lf = (p1 == 0); e_ldat = p2; end
               4'd6: if (m_busy != 0) bad = 1; else begin n_busy = 1; e_cs = 1; end
               4'd7: begin e_rq = 1; e_rf = (p1 == 0); end
               default: bad = 1;
            endcase
            if (m_busy == 1 && cdi) begin n_cd = 1; n_busy = 0; end
            if (m_busy == 2 && ldi) begin n_ld = 1; n_busy = 0; end
            if (bad) n_il = 1;
            if (op == 4'd3 && !bad) m_reg[p1] = p2;
            if (full) begin
               e_soft = 1; m_rst_left = RSTC; m_cnt = '0;
               n_busy = 0; n_cd = 0; n_ld = 0; n_il = 0;
               for (int r = 0; r < 16; r++) m_reg[r] = '0;
            end else if (op != 4'd0 && !bad) m_cnt = m_cnt + 16'd1;
         end
         m_busy = n_busy; m_cd = n_cd; m_ld = n_ld; m_il = n_il;
         m_data = e_data;

         tick();
         chk("rnd_pulses", pulses(), {e_soft, e_cs, e_ls, e_lv, e_lf, e_rq, e_rf, e_irq});
         chk("rnd_data", bus.data, e_data);
         chk("rnd_regs", regs_o, m_regs_vec());
         if (e_lv) chk("rnd_lip_data", lip_data_o, e_ldat);
      end

      // Report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/aether_cmd_decoder.md
Name: aether_cmd_decoder

Overview:
Engine-side responder for the 24-bit host command bus (4-bit instruction, 4-bit param_1, 16-bit param_2). It owns the register file and the sticky status/interrupt logic. It issues start/strobe pulses to the conv, weight-load, input-load and output-read datapaths. It returns register or result data on data_o and sits between the host bus and the engine sub-blocks inside aether_engine.

Parameters:
RegCount, 16, number of 16-bit registers addressed by param_1
RstCycles, 4, soft-reset pulse length in clk cycles (>=1)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
instruction_i  in  4  opcode: NOP=0 RST=1 RDR=2 WRR=3 LDW=4 LIP=5 CNV=6 ROP=7; 8-15 illegal
param_1_i  in  4  register index / sub-op (RST_FULL=0, LDW_CWGT=0, LIP_STRT=0, LIP_CONT=1, ROP_STRT=0, ROP_CONT=1)
param_2_i  in  16  write data / input-image data
data_o  out  16  read-back or result data
interrupt_o  out  1  level; high while any done flag is set
regs_o  out  RegCount*16  flattened register file; reg n at [16n+15:16n]
soft_rst_o  out  1  engine soft reset
conv_start_o  out  1  1-cycle pulse
conv_done_i  in  1  1-cycle pulse from conv engine
ldw_start_o  out  1  1-cycle pulse
ldw_done_i  in  1  1-cycle pulse from weight loader
lip_valid_o  out  1  1-cycle input-word strobe
lip_first_o  out  1  qualifies lip_valid_o; first word of an image
lip_data_o  out  16  input word
rop_req_o  out  1  1-cycle output-read request
rop_first_o  out  1  qualifies rop_req_o
rop_valid_i  in  1  result word valid
rop_data_i  in  16  result word

Behaviour:
- Reset: all outputs 0, all registers 0, FSM=IDLE.
- Each clk edge samples the bus; every non-NOP opcode counts as one command, so a held opcode repeats.
- Register map: 0 REG_STATS (read-only), 1 BCFG1, 2 BCFG2, 3 BCFG3, 4 CPRM1, 5 MSTRT, 6 MENDD, 15 REG_CMDCT (read-only). Other indices are plain read/write.
- REG_STATS bits: [0] conv_done, [1] ldw_done, [2] conv_busy, [3] ldw_busy, [4] illegal. Bits [0], [1], [4] are sticky; other bits are 0.
- WRR: reg[param_1] <= param_2, visible on regs_o next cycle. WRR to index 0 or 15 sets illegal; the register is unchanged.
- RDR: data_o <= reg[param_1], 1-cycle latency. RDR of index 0 returns the pre-clear value, then clears bits [0], [1], [4]. A done pulse arriving in the same cycle as the clear wins: that flag stays set.
- interrupt_o = conv_done | ldw_done, registered; it rises the cycle after the flag is set.
- FSM states: IDLE, CONV, LOADW, RESET.
  - IDLE + CNV -> CONV, conv_start_o pulses the next cycle.
  - IDLE + LDW -> LOADW, ldw_start_o pulses the next cycle.
  - CONV + conv_done_i -> IDLE and sets conv_done. LOADW + ldw_done_i -> IDLE and sets ldw_done.
  - CNV or LDW while in CONV/LOADW sets illegal and is ignored. WRR, RDR, LIP and ROP are accepted in any state except RESET.
  - conv_busy = (state==CONV); ldw_busy = (state==LOADW).
- RST (param_1=RST_FULL): from any state goes to RESET. soft_rst_o is high exactly RstCycles cycles starting the next cycle. Registers and flags clear. On exit -> IDLE.
  - Other RST sub-ops set illegal.
  - All commands received during RESET are dropped silently.
  - A done pulse during RESET is ignored.
- LIP: next cycle lip_valid_o=1, lip_data_o=param_2, lip_first_o=(param_1==LIP_STRT). Sub-op >1 sets illegal.
- ROP: next cycle rop_req_o=1, rop_first_o=(param_1==ROP_STRT). data_o <= rop_data_i on any rop_valid_i. If RDR and rop_valid_i coincide, RDR wins and the result word is dropped.
- Opcodes 8-15 set illegal, with no other effect.
- rst_i asserted mid-operation: immediate return to reset values; no pending pulse is emitted.

Optional Feature:
AETHER_CMD_COUNT_EN
- Defined: REG_CMDCT (index 15) is a 16-bit counter of accepted non-NOP commands; illegal commands and commands dropped in RESET are not counted. The counter wraps 0xFFFF->0 and clears on RST_FULL.
- Undefined: index 15 reads 0 and no counter logic is present.

Test Plan:
1. Reset, then WRR idx1=0x4002, WRR idx4=0x0040, RDR idx1 -> regs_o[31:16]=0x4002; data_o=0x4002 one cycle after RDR.
2. CNV, conv_done_i 20 cycles later -> one conv_start_o pulse; interrupt_o high the following cycle; RDR idx0 returns 0x0001; interrupt_o low after the read.
3. CNV then LDW while CONV -> no ldw_start_o; RDR idx0 = 0x0014 (busy+illegal); RDR idx0 again = 0x0004.
4. LDW with ldw_done_i in the same cycle as RDR idx0 -> read returns 0x0008; ldw_done remains set; interrupt_o stays high.
5. LIP STRT 0xABCD, LIP CONT 0x1234, ROP STRT with rop_valid_i=1 and rop_data_i=0x00FF two cycles later -> lip_first_o only on the first strobe; data_o=0x00FF.
6. RST_FULL (RstCycles=4) during CONV, with WRR issued meanwhile -> soft_rst_o high 4 cycles; regs 0; WRR dropped; FSM in IDLE; with AETHER_CMD_COUNT_EN, REG_CMDCT=0.
